// File: rtl/mac_tx_frame_pkg.sv
// Shared types and constants for the GMII transmit framer.
// The CRC helper lets sub-modules derive the reflected polynomial from CRC_POLY.
package mac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG,
    ST_LAST
  } tx_state_e;

  localparam logic [7:0]  PREAMBLE  = 8'h55;
  localparam logic [7:0]  SFD       = 8'hD5;
  localparam int          PRE_BYTES = 7;
  localparam logic [31:0] CRC_POLY  = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT  = 32'hFFFFFFFF;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/mac_tx_frame_if.sv
// Framer-side bundle: fs/fd handshake, payload FIFO read port and GMII transmit bus.
interface mac_tx_frame_if;
  logic        fs;
  logic        fd;
  logic [11:0] data_len;
  logic [7:0]  fifo_dout;
  logic        fifo_empty;
  logic        fifo_rden;
  logic [7:0]  gmii_txd;
  logic        gmii_txen;
  logic        gmii_txer;
  logic        err;

  modport master (
    input  fs, data_len, fifo_dout, fifo_empty,
    output fd, fifo_rden, gmii_txd, gmii_txen, gmii_txer, err
  );

  modport slave (
    output fs, data_len, fifo_dout, fifo_empty,
    input  fd, fifo_rden, gmii_txd, gmii_txen, gmii_txer, err
  );
endinterface

// File: rtl/mac_tx_frame_crc32_d8.sv
// Combinational one-byte step of the reflected Ethernet CRC-32 (LSB-first).
module crc32_d8
  import mac_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);
  localparam logic [31:0] POLY_R = reflect32(CRC_POLY);

  logic [31:0] c;

  always_comb begin
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ POLY_R) : (c >> 1);
  end

  assign crc_next = c;
endmodule

// File: rtl/mac_tx_frame.sv
// GMII transmit framer: preamble/SFD, FIFO payload, zero pad, CRC-32 FCS, inter-frame gap.
//   state | meaning
//   IDLE  | wait for fs, latch data_len
//   PRE   | 7 preamble bytes
//   SFD   | start delimiter, CRC seeded, first FIFO read
//   DATA  | payload bytes from the FIFO
//   PAD   | zero bytes up to the minimum payload
//   FCS   | inverted CRC, LSB byte first
//   IFG   | idle gap (first cycle carries the error byte after underflow)
//   LAST  | fd high until fs drops
module mac_tx_frame
  import mac_pkg::*;
#(
  parameter int MIN_PAYLOAD = 46,
  parameter int IFG_CYCLES  = 12
) (
  input logic            clk,
  input logic            rst,
  mac_tx_frame_if.master bus
);
  localparam logic [11:0] MIN_LEN  = 12'(MIN_PAYLOAD);
  localparam logic [11:0] IFG_LEN  = 12'(IFG_CYCLES);
  localparam logic [11:0] PRE_LAST = 12'(PRE_BYTES - 1);
  localparam logic [11:0] FCS_LAST = 12'd3;

  tx_state_e   state_q, state_d, tail_state;
  logic [11:0] cnt_q, cnt_d, len_q, len_d, pad_len, tail_cnt;
  logic [31:0] crc_q, crc_d, crc_upd;
  logic [7:0]  crc_byte, txd_c, txd_q;
  logic        txen_c, txer_c, txen_q, txer_q, err_q, want_rd, uf;

  assign pad_len    = (len_q < MIN_LEN) ? MIN_LEN - len_q : 12'd0;
  assign tail_state = (pad_len != 12'd0) ? ST_PAD : ST_FCS;
  assign tail_cnt   = (pad_len != 12'd0) ? pad_len - 12'd1 : FCS_LAST;
  assign crc_byte   = (state_q == ST_DATA) ? bus.fifo_dout : 8'h00;

  crc32_d8 u_crc (.crc(crc_q), .data(crc_byte), .crc_next(crc_upd));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    crc_d   = crc_q;
    want_rd = 1'b0;
    uf      = 1'b0;
    txd_c   = 8'h00;
    txen_c  = err_q;
    txer_c  = err_q;
    case (state_q)
      ST_IDLE: if (bus.fs) begin
        len_d   = bus.data_len;
        cnt_d   = PRE_LAST;
        state_d = ST_PRE;
      end
      ST_PRE: begin
        txd_c  = PREAMBLE;
        txen_c = 1'b1;
        if (cnt_q == 12'd0) state_d = ST_SFD;
        else                cnt_d   = cnt_q - 12'd1;
      end
      ST_SFD: begin
        txd_c  = SFD;
        txen_c = 1'b1;
        crc_d  = CRC_INIT;
        if (len_q != 12'd0) begin
          want_rd = 1'b1;
          state_d = ST_DATA;
          cnt_d   = len_q - 12'd1;
        end else begin
          state_d = tail_state;
          cnt_d   = tail_cnt;
        end
      end
      ST_DATA: begin
        txd_c   = bus.fifo_dout;
        txen_c  = 1'b1;
        crc_d   = crc_upd;
        want_rd = (cnt_q != 12'd0);
        if (cnt_q == 12'd0) begin
          state_d = tail_state;
          cnt_d   = tail_cnt;
        end else begin
          cnt_d = cnt_q - 12'd1;
        end
      end
      ST_PAD: begin
        txen_c = 1'b1;
        crc_d  = crc_upd;
        if (cnt_q == 12'd0) begin
          state_d = ST_FCS;
          cnt_d   = FCS_LAST;
        end else begin
          cnt_d = cnt_q - 12'd1;
        end
      end
      ST_FCS: begin
        txd_c  = ~crc_q[7:0];
        txen_c = 1'b1;
        crc_d  = {8'h00, crc_q[31:8]};
        if (cnt_q == 12'd0) begin
          state_d = ST_IFG;
          cnt_d   = IFG_LEN - 12'd1;
        end else begin
          cnt_d = cnt_q - 12'd1;
        end
      end
      ST_IFG: begin
        if (cnt_q == 12'd0) state_d = ST_LAST;
        else                cnt_d   = cnt_q - 12'd1;
      end
      ST_LAST: if (!bus.fs) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Underflow: the byte in hand still goes out; one extra IFG cycle carries the error byte.
    uf = want_rd & bus.fifo_empty;
    if (uf) begin
      state_d = ST_IFG;
      cnt_d   = IFG_LEN;
    end
  end

  assign bus.fifo_rden = want_rd & ~bus.fifo_empty;
  assign bus.fd        = (state_q == ST_LAST);
  assign bus.err       = err_q;
  assign bus.gmii_txd  = txd_q;
  assign bus.gmii_txen = txen_q;
  assign bus.gmii_txer = txer_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 12'd0;
      len_q   <= 12'd0;
      crc_q   <= 32'd0;
      err_q   <= 1'b0;
      txd_q   <= 8'h00;
      txen_q  <= 1'b0;
      txer_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      crc_q   <= crc_d;
      err_q   <= uf;
      txd_q   <= txd_c;
      txen_q  <= txen_c;
      txer_q  <= txer_c;
    end
  end
endmodule

// File: tb/tb_mac_tx_frame.sv
// Randomized frame bench for mac_tx_frame against a byte-list reference model.
module tb_mac_tx_frame;
  localparam int IFG = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #4 clk = ~clk;

  mac_tx_frame_if bus0();
  mac_tx_frame_if bus1();

  mac_tx_frame #(.MIN_PAYLOAD(46), .IFG_CYCLES(IFG)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  mac_tx_frame #(.MIN_PAYLOAD(0),  .IFG_CYCLES(IFG)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // FIFO models: read data valid the cycle after fifo_rden.
  logic [7:0] mem [2][0:4095];
  int rd [2] = '{0, 0};
  int wr [2] = '{0, 0};

  always @(posedge clk) begin
    if (bus0.fifo_rden) begin
      bus0.fifo_dout <= mem[0][rd[0] % 4096];
      rd[0] <= rd[0] + 1;
    end
    if (bus1.fifo_rden) begin
      bus1.fifo_dout <= mem[1][rd[1] % 4096];
      rd[1] <= rd[1] + 1;
    end
  end
  assign bus0.fifo_empty = (rd[0] == wr[0]);
  assign bus1.fifo_empty = (rd[1] == wr[1]);

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] pay [0:4095];
  logic [7:0] expb [0:4199];
  logic [7:0] cap [0:4199];
  int ncap, nexp;

  // Bit-serial reference CRC over payload plus zero padding, result already inverted.
  function automatic logic [31:0] ref_fcs(input int len, input int blen);
    logic [31:0] c;
    logic [7:0]  b;
    logic        fb;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < blen; i++) begin
      b = (i < len) ? pay[i] : 8'h00;
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ b[j];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return ~c;
  endfunction

  task automatic drive(input int inst, input logic fs, input logic [11:0] len);
    if (inst == 0) begin bus0.fs = fs; bus0.data_len = len; end
    else           begin bus1.fs = fs; bus1.data_len = len; end
  endtask

  task automatic sample(input int inst, output logic txen, output logic txer, output logic errp,
                        output logic fd, output logic rden, output logic empty, output logic [7:0] txd);
    if (inst == 0) begin
      txen = bus0.gmii_txen; txer = bus0.gmii_txer; errp = bus0.err; fd = bus0.fd;
      rden = bus0.fifo_rden; empty = bus0.fifo_empty; txd = bus0.gmii_txd;
    end else begin
      txen = bus1.gmii_txen; txer = bus1.gmii_txer; errp = bus1.err; fd = bus1.fd;
      rden = bus1.fifo_rden; empty = bus1.fifo_empty; txd = bus1.gmii_txd;
    end
  endtask

  task automatic run_frame(input int inst, input int len, input int avail, input int hold, input string name);
    int minp, blen, first, last, fd_c, nrd, viol, nerr, ntxer, err_c, txer_c;
    logic txen, txer, errp, fd, rden, empty, fd_seen, uf;
    logic [7:0] txd;
    logic [31:0] fcs;
    minp = (inst == 0) ? 46 : 0;
    uf   = (avail < len);
    blen = (len > minp) ? len : minp;
    for (int i = 0; i < avail; i++) mem[inst][(rd[inst] + i) % 4096] = pay[i];
    wr[inst] = rd[inst] + avail;
    nexp = 0;
    for (int i = 0; i < 7; i++) expb[nexp++] = 8'h55;
    expb[nexp++] = 8'hD5;
    if (uf) begin
      for (int i = 0; i < avail; i++) expb[nexp++] = pay[i];
    end else begin
      for (int i = 0; i < blen; i++) expb[nexp++] = (i < len) ? pay[i] : 8'h00;
      fcs = ref_fcs(len, blen);
      for (int i = 0; i < 4; i++) expb[nexp++] = fcs[8*i +: 8];
    end
    ncap = 0; first = -1; last = -1; fd_c = -1; nrd = 0; viol = 0;
    nerr = 0; ntxer = 0; err_c = -1; txer_c = -1; fd_seen = 1'b0;
    @(negedge clk);
    drive(inst, 1'b1, 12'(len));
    for (int c = 0; c < 600 && !fd_seen; c++) begin
      @(negedge clk);
      if (c == 0) drive(inst, 1'b1, 12'($urandom));
      sample(inst, txen, txer, errp, fd, rden, empty, txd);
      if (txen) begin
        if (first < 0) first = c;
        last = c;
        cap[ncap++] = txd;
      end
      if (txer) begin ntxer++; txer_c = c; end
      if (errp) begin nerr++; err_c = c; end
      if (rden) begin nrd++; if (empty) viol++; end
      if (fd) begin fd_seen = 1'b1; fd_c = c; end
    end
    check_val({name, " fd_seen"}, 32'(fd_seen), 32'd1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      sample(inst, txen, txer, errp, fd, rden, empty, txd);
      check_val({name, " fd_hold"}, 32'(fd), 32'd1);
    end
    drive(inst, 1'b0, 12'd0);
    @(negedge clk);
    sample(inst, txen, txer, errp, fd, rden, empty, txd);
    check_val({name, " fd_drop"}, 32'(fd), 32'd0);
    check_val({name, " start_lat"}, 32'(first), 32'd1);
    check_val({name, " txen_len"}, 32'(ncap), uf ? 32'(8 + avail + 1) : 32'(8 + blen + 4));
    check_val({name, " txen_gapless"}, 32'(last - first + 1), 32'(ncap));
    for (int i = 0; i < nexp && i < ncap; i++) check_val({name, " byte"}, 32'(cap[i]), 32'(expb[i]));
    check_val({name, " fd_gap"}, 32'(fd_c - last), 32'(IFG));
    check_val({name, " rden_cnt"}, 32'(nrd), uf ? 32'(avail) : 32'(len));
    check_val({name, " rden_empty"}, 32'(viol), 32'd0);
    check_val({name, " err_cnt"}, 32'(nerr), uf ? 32'd1 : 32'd0);
    check_val({name, " txer_cnt"}, 32'(ntxer), uf ? 32'd1 : 32'd0);
    if (uf) begin
      check_val({name, " txer_after_err"}, 32'(txer_c - err_c), 32'd1);
      check_val({name, " txer_last_byte"}, 32'(txer_c), 32'(last));
    end
  endtask

  task automatic rand_pay(input int n);
    for (int i = 0; i < n; i++) pay[i] = 8'($urandom);
  endtask

  initial begin
    logic txen, txer, errp, fd, rden, empty;
    logic [7:0] txd;
    logic [7:0] ck [0:3];
    string s9;
    drive(0, 1'b0, 12'd0);
    drive(1, 1'b0, 12'd0);
    repeat (3) @(negedge clk);
    sample(0, txen, txer, errp, fd, rden, empty, txd);
    check_val("rst fd", 32'(fd), 32'd0);
    check_val("rst rden", 32'(rden), 32'd0);
    check_val("rst txd", 32'(txd), 32'd0);
    check_val("rst txen", 32'(txen), 32'd0);
    check_val("rst txer", 32'(txer), 32'd0);
    check_val("rst err", 32'(errp), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 64; i++) pay[i] = 8'(i);
    run_frame(0, 64, 64, 0, "basic");

    s9 = "123456789";
    for (int i = 0; i < 9; i++) pay[i] = s9[i];
    run_frame(1, 9, 9, 0, "crc9");
    ck[0] = 8'h26; ck[1] = 8'h39; ck[2] = 8'hF4; ck[3] = 8'hCB;
    for (int i = 0; i < 4; i++) check_val("crc9 check_value", 32'(cap[ncap - 4 + i]), 32'(ck[i]));

    rand_pay(10);
    run_frame(0, 10, 10, 0, "pad10");
    run_frame(0, 0, 0, 0, "zero_len");
    run_frame(1, 0, 0, 0, "zero_len_nopad");

    for (int k = 0; k < 5; k++) begin
      int n;
      n = $urandom_range(1, 100);
      rand_pay(n);
      run_frame(0, n, n, 0, "rand46");
    end
    for (int k = 0; k < 3; k++) begin
      int n;
      n = $urandom_range(1, 30);
      rand_pay(n);
      run_frame(1, n, n, 0, "rand0");
    end

    rand_pay(20);
    run_frame(0, 20, 5, 0, "underflow");

    rand_pay(64);
    for (int i = 0; i < 64; i++) mem[0][(rd[0] + i) % 4096] = pay[i];
    wr[0] = rd[0] + 64;
    @(negedge clk);
    drive(0, 1'b1, 12'd64);
    repeat (30) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    sample(0, txen, txer, errp, fd, rden, empty, txd);
    check_val("midrst fd", 32'(fd), 32'd0);
    check_val("midrst rden", 32'(rden), 32'd0);
    check_val("midrst txd", 32'(txd), 32'd0);
    check_val("midrst txen", 32'(txen), 32'd0);
    check_val("midrst txer", 32'(txer), 32'd0);
    check_val("midrst err", 32'(errp), 32'd0);
    drive(0, 1'b0, 12'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      sample(0, txen, txer, errp, fd, rden, empty, txd);
      check_val("midrst quiet", 32'(txen), 32'd0);
    end
    rand_pay(64);
    run_frame(0, 64, 64, 5, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/mac_tx_frame.md
# mac_tx_frame

Ethernet MAC transmit framer, the stage directly downstream of the MAC TX payload FIFO. On a start strobe it reads `data_len` payload bytes from the FIFO and emits a complete GMII frame:
- 7 × 0x55 preamble and 0xD5 SFD.
- Payload, zero-padded to `MIN_PAYLOAD` bytes.
- IEEE 802.3 CRC-32 FCS.

It then enforces an inter-frame gap and reports completion on the same `fs`/`fd` handshake used by the FIFO-fill stage.

## Interface
Parameters:
- `MIN_PAYLOAD`, 46: minimum payload bytes; shorter payloads are zero-padded up to this length.
- `IFG_CYCLES`, 12: idle cycles inserted after the FCS before `fd` is raised.

Ports:
- `clk`  in  1  transmit byte clock (125 MHz GMII).
- `rst`  in  1  reset; asynchronous, active-low.
- `fs`  in  1  frame start; level, held high until `fd` is seen.
- `fd`  out  1  frame done; high in LAST.
- `data_len`  in  12  payload byte count, sampled in the cycle `fs` is accepted.
- `fifo_dout`  in  8  FIFO read data, valid the cycle after `fifo_rden`.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rden`  out  1  FIFO read enable.
- `gmii_txd`  out  8  transmit byte, registered.
- `gmii_txen`  out  1  transmit enable, registered.
- `gmii_txer`  out  1  transmit error, registered.
- `err`  out  1  one-cycle pulse on FIFO underflow.

## Operation
- **Reset (`rst` low):** state IDLE. All outputs 0: `fd`, `fifo_rden`, `gmii_txd`, `gmii_txen`, `gmii_txer`, `err`. Counters and CRC are cleared.
- **IDLE:** if `fs`=1, latch `data_len` and go to PRE.
- **PRE:** 7 cycles, byte 0x55.
- **SFD:** 1 cycle, byte 0xD5.
  - If `data_len`>0, assert `fifo_rden`.
  - CRC register is set to 0xFFFFFFFF.
- **DATA:** `data_len` cycles; each byte is the `fifo_dout` returned for the previous read.
  - `fifo_rden` is asserted in every DATA cycle except the last.
  - `data_len`=0 skips DATA.
- **PAD:** max(0, `MIN_PAYLOAD`−`data_len`) cycles, byte 0x00.
- **FCS:** 4 cycles; bytes are ~CRC, least-significant byte first.
- **IFG:** `IFG_CYCLES` cycles with `gmii_txen`=0.
- **LAST:** `fd`=1. Return to IDLE when `fs`=0; stay while `fs`=1.
- **CRC:**
  - Reflected CRC-32, polynomial 0x04C11DB7, processed LSB-first.
  - Updated with every DATA and PAD byte; preamble and SFD excluded.
- **Underflow:** `fifo_rden` would be asserted while `fifo_empty`=1.
  - Do not read.
  - Pulse `err`.
  - Drive `gmii_txer`=1 with `gmii_txen`=1 for one byte.
  - Go to IFG, then LAST; no FCS is sent.
- **Read discipline:** `fifo_rden` is never asserted while `fifo_empty`=1.
- **Length/counter widths:** `data_len` is unsigned 12-bit with no clamping; the byte counter is 12-bit.
- **`fs` outside IDLE and LAST:** ignored. `data_len` changes after latch are ignored.

## Timing
- **Start latency:** `fs` is sampled in IDLE at edge N.
  - State is PRE from N+1.
  - First `gmii_txen`=1 with 0x55 appears after edge N+2, because the output register adds one cycle.
- **Frame length:** `gmii_txen` is high for exactly 8 + max(`data_len`,`MIN_PAYLOAD`) + 4 consecutive cycles, with no gaps.
- **FIFO read latency:** `fifo_rden` at cycle k → `fifo_dout` captured at k+1 → byte on `gmii_txd` at k+2.
- **`fd` timing:** rises `IFG_CYCLES` cycles after the last FCS state cycle.
- **`err` timing:** pulses in the cycle the underflow is detected; `gmii_txer` follows one cycle later.
- **Reset mid-frame:** `gmii_txen` drops asynchronously. No FCS or gap is sent. The next `fs` starts a fresh frame.

## Structure
- Shared package (`mac_pkg`):
  - State encoding: IDLE, PRE, SFD, DATA, PAD, FCS, IFG, LAST.
  - Constants: PREAMBLE = 8'h55, SFD = 8'hD5, CRC_POLY, CRC_INIT.
- Sub-module `crc32_d8`: combinational next-CRC for one 8-bit input byte. The CRC register stays in `mac_tx_frame`.
- The top holds the FSM, the byte counter, and the output register stage.

## Test plan
- **Basic frame:** `MIN_PAYLOAD`=46, `data_len`=64, FIFO preloaded 0x00..0x3F.
  - `gmii_txen` high 76 cycles.
  - Bytes are 7×55, D5, 00..3F, then 4 FCS bytes equal to the software CRC-32 model.
  - `fd` rises 12 cycles after `gmii_txen` falls.
- **CRC check value:** `MIN_PAYLOAD`=0, `data_len`=9, FIFO holds "123456789".
  - FCS bytes are 26, 39, F4, CB.
  - `gmii_txen` high 21 cycles.
- **Padding:** `data_len`=10, `MIN_PAYLOAD`=46.
  - 10 data bytes, then 36 × 0x00.
  - `gmii_txen` high 58 cycles.
  - Exactly 10 `fifo_rden` pulses.
- **Zero length:** `data_len`=0.
  - No `fifo_rden`.
  - 46 zero bytes plus FCS.
  - `gmii_txen` high 58 cycles.
- **Underflow:** `data_len`=20, FIFO holds 5 bytes.
  - 5 data bytes are sent.
  - `err` pulses once.
  - One byte with `gmii_txer`=1.
  - No FCS; `fd` follows the IFG.
  - `fifo_rden` is never asserted while empty.
- **Reset and handshake:** assert `rst` low during DATA.
  - All outputs 0 immediately; state IDLE.
  - Hold `fs` high through LAST: `fd` stays 1.
  - Drop `fs`: `fd`=0 next cycle.
  - Next `fs` yields a full, correct frame.
